adc_spi_cfg_sequencer: RTL and testbench

ADC_SPI_CFG_SEQUENCER -- requirements
Module: adc_spi_cfg_sequencer

---
 rtl/adc_spi_cfg_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_adc_spi_cfg_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// adc_spi_cfg_sequencer
//
// Front end for an ADC configuration SPI engine. After reset it fetches
// INIT_LEN entries from an external init table and issues each one as an SPI
// transaction. Once the table has been issued, it serves single host register
// reads/writes. Every transaction is guarded by a timeout, so a hung engine
// cannot stall the sequence.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   tbl_addr / tbl_data        init-table index out, {addr,value} back a cycle later
//   host_valid/addr/wdata      host request (addr[7]=1 write, 0 read)
//   host_ready                 request accepted this cycle (combinational)
//   host_rvalid/rdata/err      one-cycle completion, read data, timeout flag
//   spi_reg_addr/config_value  transaction held stable for the engine
//   spi_start                  one-cycle start pulse
//   spi_idle, spi_rdata/rdy    engine status, read data and its valid pulse
//   init_done, init_err        init table complete / some init entry timed out
// ---------------------------------------------------------------------------
module adc_spi_cfg_sequencer #(
  parameter int INIT_LEN = 8,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  tbl_addr,
  input  logic [23:0] tbl_data,
  input  logic        host_valid,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ready,
  output logic        host_rvalid,
  output logic [15:0] host_rdata,
  output logic        host_err,
  output logic [7:0]  spi_reg_addr,
  output logic [15:0] spi_config_value,
  output logic        spi_start,
  input  logic        spi_idle,
  input  logic [15:0] spi_rdata,
  input  logic        spi_rdy,
  output logic        init_done,
  output logic        init_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Holds 0..32 so the "all entries issued" compare works for INIT_LEN=32.
  localparam int IDX_W = 6;

  typedef enum logic [2:0] {
    RST_WAIT, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE, RESP
  } state_t;

  // One in-flight transaction; addr[7] selects write (1) or read (0).
  typedef struct packed {
    logic        is_host;
    logic [7:0]  addr;
    logic [15:0] value;
  } txn_t;

  state_t           state;
  txn_t             txn;
  logic             fetch_wait;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_nxt;
  logic             tmo_hit;
  logic             txn_err;
  logic             txn_done;
  logic             txn_to;

  // The engine sees the latched transaction directly, so the values stay
  // put from ISSUE until the next transaction is loaded.
  assign spi_reg_addr     = txn.addr;
  assign spi_config_value = txn.value;

  // Accept is same-cycle so the host sees ready in the cycle its request is
  // taken. Before init_done the host is locked out entirely.
  assign host_ready = (state == RST_WAIT) && spi_idle && init_done && host_valid;

  // Saturating timeout counter; the abort fires on the edge where it reaches
  // TIMEOUT, i.e. TIMEOUT cycles after the spi_start cycle. Saturation keeps
  // tmo_hit asserted if the limit was reached while moving to WAIT_DONE.
  assign tmo_nxt = (tmo_cnt == CNT_W'(TIMEOUT)) ? tmo_cnt : tmo_cnt + 1'b1;
  assign tmo_hit = (tmo_nxt == CNT_W'(TIMEOUT));

  // Completion / abort decode. A read only completes on spi_rdy; an idle
  // engine without rdy leaves it waiting (and eventually timing out).
  always_comb begin
    txn_done = 1'b0;
    txn_to   = 1'b0;
    if (state == WAIT_BUSY) begin
      txn_to = spi_idle && tmo_hit;
    end
    if (state == WAIT_DONE) begin
      txn_done = txn.addr[7] ? spi_idle : spi_rdy;
      txn_to   = !txn_done && tmo_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RST_WAIT;
      txn         <= '0;
      fetch_wait  <= 1'b0;
      idx         <= '0;
      tmo_cnt     <= '0;
      txn_err     <= 1'b0;
      tbl_addr    <= '0;
      spi_start   <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      host_err    <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
    end else begin
      spi_start   <= 1'b0;
      host_rvalid <= 1'b0;

      case (state)
        RST_WAIT: begin
          if (spi_idle) begin
            if (!init_done) begin
              tbl_addr   <= idx[4:0];
              fetch_wait <= 1'b1;
              state      <= FETCH;
            end else if (host_valid) begin
              txn       <= {1'b1, host_addr, host_wdata};
              tmo_cnt   <= '0;
              spi_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end

        // First cycle lets the table answer the new tbl_addr; the second
        // captures the entry and launches it.
        FETCH: begin
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            txn       <= {1'b0, tbl_data};
            tmo_cnt   <= '0;
            spi_start <= 1'b1;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          tmo_cnt <= tmo_nxt;
          state   <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          tmo_cnt <= tmo_nxt;
          if (!spi_idle) state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          tmo_cnt <= tmo_nxt;
        end

        RESP: begin
          if (!txn.is_host) begin
            idx <= idx + 1'b1;
            if (txn_err) init_err <= 1'b1;
            if ((idx + 1'b1) == IDX_W'(INIT_LEN)) init_done <= 1'b1;
          end
          state <= RST_WAIT;
        end

        default: state <= RST_WAIT;
      endcase

      // Finish (normal or aborted) from either wait state. Host responses are
      // registered on entry so host_rvalid lines up with the RESP cycle.
      if (txn_done || txn_to) begin
        state   <= RESP;
        txn_err <= txn_to;
        if (txn.is_host) begin
          host_rvalid <= 1'b1;
          host_err    <= txn_to;
          host_rdata  <= (txn_done && !txn.addr[7]) ? spi_rdata : 16'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_spi_cfg_sequencer
//
// Directed sequence with randomized host traffic and engine timing. A
// behavioural engine (random busy time, random rdy lag, optional "dead" start)
// and a registered init-table ROM drive the DUT. Expected results come from a
// reference register array plus a queue of expected SPI transactions in issue
// order.
// ---------------------------------------------------------------------------
module tb_adc_spi_cfg_sequencer;

  localparam int INIT_LEN = 3;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        host_valid = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ready;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        host_err;
  logic [7:0]  spi_reg_addr;
  logic [15:0] spi_config_value;
  logic        spi_start;
  logic        spi_idle = 1'b1;
  logic [15:0] spi_rdata = '0;
  logic        spi_rdy = 1'b0;
  logic        init_done;
  logic        init_err;

  adc_spi_cfg_sequencer #(.INIT_LEN(INIT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .host_err(host_err),
    .spi_reg_addr(spi_reg_addr), .spi_config_value(spi_config_value),
    .spi_start(spi_start), .spi_idle(spi_idle),
    .spi_rdata(spi_rdata), .spi_rdy(spi_rdy),
    .init_done(init_done), .init_err(init_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- init table ROM (one-cycle registered read) -------------
  function automatic logic [23:0] rom(input logic [4:0] i);
    case (i)
      5'd0:    return 24'h811234;
      5'd1:    return 24'h820000;
      5'd2:    return 24'h050000;
      default: return 24'h000000;
    endcase
  endfunction

  always @(posedge clk) tbl_data <= rom(tbl_addr);

  // ---------------- behavioural SPI engine ---------------------------------
  function automatic logic [15:0] dflt(input int i);
    if (i == 16) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  logic [15:0]  mem [128];
  logic [127:0] wr_flag = '0;
  logic [7:0]   cur_addr = '0;
  logic [15:0]  cur_val = '0;
  int           busy_cnt = 0;
  int           rdy_cnt = 0;
  int           rdy_lag = 0;
  int           eng_starts = 0;
  int           dead_idx = -1;   // engine ignores the start with this index
  bit           eng_long = 1'b0; // fixed long busy time, rdy with idle

  function automatic logic [15:0] rd_val(input logic [6:0] a);
    return wr_flag[a] ? mem[a] : dflt(int'(a));
  endfunction

  always @(posedge clk) begin
    spi_rdy   <= 1'b0;
    spi_rdata <= 16'($urandom);
    if (spi_start) begin
      eng_starts <= eng_starts + 1;
      rdy_cnt    <= 0;
      if (eng_starts != dead_idx) begin
        cur_addr <= spi_reg_addr;
        cur_val  <= spi_config_value;
        busy_cnt <= eng_long ? 10 : int'($urandom_range(2, 6));
        rdy_lag  <= eng_long ? 0 : int'($urandom_range(0, 3));
        spi_idle <= 1'b0;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) begin
        spi_idle <= 1'b1;
        if (cur_addr[7]) begin
          mem[cur_addr[6:0]]     <= cur_val;
          wr_flag[cur_addr[6:0]] <= 1'b1;
        end else if (rdy_lag == 0) begin
          spi_rdy   <= 1'b1;
          spi_rdata <= rd_val(cur_addr[6:0]);
        end else begin
          rdy_cnt <= rdy_lag;
        end
      end
    end else if (rdy_cnt > 0) begin
      rdy_cnt <= rdy_cnt - 1;
      if (rdy_cnt == 1) begin
        spi_rdy   <= 1'b1;
        spi_rdata <= rd_val(cur_addr[6:0]);
      end
    end
  end

  // ---------------- reference model ----------------------------------------
  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  logic [15:0] ref_mem [128];

  // Every start must match the next expected transaction, in order, and may
  // only be issued to an engine that has finished its previous operation.
  always @(negedge clk) begin
    if (spi_start) begin
      start_cyc = cyc;
      chk("start_engine_idle", 32'((busy_cnt != 0) || (rdy_cnt != 0)), 32'd0);
      chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        chk("start_addr", 32'(spi_reg_addr), 32'(e_mon.a));
        if (e_mon.a[7]) chk("start_value", 32'(spi_config_value), 32'(e_mon.v));
      end
    end
  end

  task automatic push_init();
    logic [23:0] w;
    for (int i = 0; i < INIT_LEN; i++) begin
      w = rom(5'(i));
      exp_q.push_back(exp_t'(w));
      if (w[23]) ref_mem[w[22:16]] = w[15:0];
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_tbl_addr"},  32'(tbl_addr), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
    chk({tag, "_init_err"},  32'(init_err), 32'd0);
    chk({tag, "_rvalid"},    32'(host_rvalid), 32'd0);
    chk({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    chk({tag, "_spi_addr"},  32'(spi_reg_addr), 32'd0);
    chk({tag, "_ready"},     32'(host_ready), 32'd0);
    reset = 1'b0;
  endtask

  task automatic host_txn(input string tag, input logic [7:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input logic exp_err,
                          input bit chk_first, output int lat);
    bit acc, early, seen_done, first_ok, got, unstable;
    logic [15:0] rd;
    logic er;
    acc = 0; early = 0; seen_done = 0; first_ok = 0; got = 0; unstable = 0;
    rd = '0; er = 1'b0; lat = -1;
    exp_q.push_back(exp_t'({a, d}));
    @(negedge clk);
    host_valid = 1'b1; host_addr = a; host_wdata = d;
    for (int n = 0; n < 300 && !acc; n++) begin
      #1;
      if (host_ready && !init_done) early = 1;
      if (init_done && !seen_done) begin seen_done = 1; first_ok = host_ready; end
      if (host_ready) acc = 1;
      @(negedge clk);
    end
    host_valid = 1'b0;
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    chk({tag, "_ready_pre_init"}, 32'(early), 32'd0);
    if (chk_first) chk({tag, "_first_idle_accept"}, 32'(first_ok), 32'd1);
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (host_rvalid) begin
        got = 1; rd = host_rdata; er = host_err; lat = cyc - start_cyc;
      end else if (spi_reg_addr !== a || (a[7] && spi_config_value !== d)) begin
        unstable = 1;
      end
    end
    chk({tag, "_rvalid"}, 32'(got), 32'd1);
    chk({tag, "_rdata"},  32'(rd), 32'(exp_rd));
    chk({tag, "_err"},    32'(er), 32'(exp_err));
    chk({tag, "_stable"}, 32'(unstable), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(host_rvalid), 32'd0);
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    int lat, nrv;
    bit acc, fin;
    logic [7:0]  a;
    logic [15:0] d;

    for (int i = 0; i < 128; i++) ref_mem[i] = dflt(i);

    // Reset values, then init with a host read already pending.
    do_reset("rst");
    push_init();
    host_txn("rd_10", 8'h10, 16'h5555, ref_mem[16], 1'b0, 1'b1, lat);
    chk("init_done_1", 32'(init_done), 32'd1);
    chk("init_err_1",  32'(init_err), 32'd0);

    // Host write then read-back.
    host_txn("wr_90", 8'h90, 16'h00AA, 16'h0, 1'b0, 1'b0, lat);
    ref_mem[16] = 16'h00AA;
    host_txn("rd_10b", 8'h10, 16'h0, ref_mem[16], 1'b0, 1'b0, lat);

    // Host write to an engine that never leaves idle: timeout response.
    dead_idx = eng_starts;
    host_txn("wr_tmo", 8'h93, 16'h7777, 16'h0, 1'b1, 1'b0, lat);
    chk("tmo_latency", 32'(lat), 32'(TIMEOUT));
    host_txn("rd_13", 8'h13, 16'h0, ref_mem[19], 1'b0, 1'b0, lat);

    // Random host traffic over a small register window.
    for (int k = 0; k < 16; k++) begin
      a = {1'($urandom_range(0, 1)), 4'b0001, 3'($urandom_range(0, 7))};
      d = 16'($urandom);
      host_txn("rnd", a, d, a[7] ? 16'h0 : ref_mem[a[6:0]], 1'b0, 1'b0, lat);
      if (a[7]) ref_mem[a[6:0]] = d;
    end

    // Reset while a host read sits in WAIT_DONE: response dropped, init
    // restarts from entry 0 once the engine is idle again.
    eng_long = 1'b1;
    exp_q.push_back(exp_t'({8'h10, 16'h0}));
    @(negedge clk);
    host_valid = 1'b1; host_addr = 8'h10; host_wdata = 16'h0;
    acc = 0;
    for (int n = 0; n < 50 && !acc; n++) begin
      #1;
      if (host_ready) acc = 1;
      @(negedge clk);
    end
    host_valid = 1'b0;
    chk("mid_accept", 32'(acc), 32'd1);
    repeat (3) @(negedge clk);
    eng_long = 1'b0;
    do_reset("mid_rst");
    push_init();
    nrv = 0; fin = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      if (host_rvalid) nrv++;
      if (init_done) fin = 1;
    end
    chk("mid_no_rvalid", 32'(nrv), 32'd0);
    chk("mid_init_done", 32'(fin), 32'd1);
    chk("mid_init_err", 32'(init_err), 32'd0);

    // First init entry times out: error flagged, the rest still issued.
    do_reset("err_rst");
    dead_idx = eng_starts;
    push_init();
    fin = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      if (init_done) fin = 1;
    end
    chk("err_init_done", 32'(fin), 32'd1);
    chk("err_init_err", 32'(init_err), 32'd1);
    host_txn("rd_05", 8'h05, 16'h0, ref_mem[5], 1'b0, 1'b0, lat);

    chk("spi_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
